fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch front end. Consumes the next-PC stream, issues word fetches to instruction memory over a req/gnt/rvalid handshake, and buffers returned words with their PCs in a small FIFO.
- Delivers instructions to decode over a valid/ready handshake.
- Supports a redirect (taken branch/jump) that flushes buffered and in-flight instructions.
- Sits between the PC logic and instruction memory on one side, and decode on the other.

Parameters:
- DATA_WIDTH, 32, width of addresses, PCs and instruction words.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- redirect_valid  input  1  flush and restart fetch at redirect_pc.
- redirect_pc  input  DATA_WIDTH  redirect target; bits [1:0] ignored and treated as 0.
- imem_req  output  1  fetch request valid.
- imem_addr  output  DATA_WIDTH  fetch address, word aligned.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  response data valid; at least 1 cycle after gnt; in order.
- imem_rdata  input  DATA_WIDTH  instruction word.
- instr_valid  output  1  FIFO head valid.
- instr_ready  input  1  decode accepts the head.
- instr  output  DATA_WIDTH  head instruction word.
- instr_pc  output  DATA_WIDTH  PC of the head instruction.

Behaviour:
- Registers:
  - fetch_pc: next fetch address.
  - req_pc: PC of the in-flight fetch.
  - state: REQ, WAIT or DROP.
  - started flag.
  - FIFO: entries of {word, pc}, rd/wr pointers, count.
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC, state=REQ, FIFO empty, started=0.
  - Outputs: imem_req=0, instr_valid=0. imem_addr, instr and instr_pc are don't-care but must not be X-propagating; drive 0.
  - started sets on the first clk edge with rst=1.
- At most one fetch is outstanding at any time.
- imem_req = started & (state==REQ) & (count<FIFO_DEPTH) & !redirect_valid.
- imem_addr = fetch_pc, combinational.
- REQ state:
  - On imem_req & imem_gnt: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps modulo 2^DATA_WIDTH), go to WAIT.
  - No gnt: hold; address stays stable.
- WAIT state: on imem_rvalid, push {imem_rdata, req_pc}, go to REQ. Space is guaranteed because a request is issued only when count<FIFO_DEPTH.
- DROP state: on imem_rvalid, discard the data and go to REQ.
- imem_rvalid in REQ is a protocol error; ignore it (the bench asserts it never occurs).
- Decode side:
  - instr_valid = (count!=0) & !redirect_valid.
  - instr and instr_pc come from the FIFO head.
  - Pop on instr_valid & instr_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Decode sees each fetched word at the earliest 1 cycle after its rvalid.
- Redirect (redirect_valid=1, any state, single cycle suffices):
  - FIFO cleared (count=0, pointers=0); no pop that cycle.
  - fetch_pc <= {redirect_pc[DATA_WIDTH-1:2], 2'b00}.
  - State transitions on redirect:
    - REQ stays REQ.
    - WAIT without rvalid goes to DROP.
    - WAIT with rvalid discards the data and goes to REQ.
    - DROP with rvalid goes to REQ; otherwise stays DROP.
  - First new request is issued the cycle after redirect_valid deasserts.
- Back-to-back redirects: the last one wins.
- Reset mid-operation: any in-flight response is lost; instruction memory shares this reset.
- Throughput: 1 instruction per 2 cycles with single-cycle gnt and rvalid one cycle later. This is accepted for this revision.

Test Plan:
- Reset release, mem gnt immediate, rvalid next cycle, instr_ready=1 -> imem_addr sequence 0x0,0x4,0x8; instr_pc follows 0x0,0x4,0x8 with matching words; instr_valid=0 during reset.
- instr_ready=0, FIFO_DEPTH=2 -> after two words buffered, imem_req stays 0. Ready=1 for one cycle -> one pop, one new request at the next sequential address.
- Redirect to 0x103 while in WAIT, rvalid arrives 3 cycles later -> that word is dropped, FIFO empty; next imem_addr=0x100; first delivered instr_pc=0x100.
- Redirect in the same cycle as rvalid and a pending pop -> no push, no pop, instr_valid=0 that cycle; next request at the redirect target.
- fetch_pc=0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000 (wrap).
- rst asserted while in WAIT with 1 entry buffered -> immediately instr_valid=0, imem_req=0; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Bundle between the fetch unit, PC/redirect source, instruction memory and decode.
// valid/ready: a beat transfers on a rising edge where both are high; imem_req/imem_gnt behave the same way.
interface fetch_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  imem_req;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic                  imem_gnt;
    logic                  imem_rvalid;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] instr_pc;
    logic [1:0]            fsm_state;

    modport master (
        input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instr, instr_pc, fsm_state
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, fsm_state
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: one outstanding word fetch, small {word, pc} buffer
// toward decode, and a redirect that flushes buffered and in-flight instructions.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                state;
    logic                  started;
    logic [DATA_WIDTH-1:0] fetch_pc;
    logic [DATA_WIDTH-1:0] req_pc;

    logic [DATA_WIDTH-1:0] fifo_word [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;

    logic req_fire;
    logic push;
    logic pop;

    // A request only goes out when a free slot exists, so the response can always be pushed.
    assign bus.imem_req    = started && (state == ST_REQ) && (count < DEPTH_C) && !bus.redirect_valid;
    assign bus.imem_addr   = fetch_pc;
    assign bus.instr_valid = (count != '0) && !bus.redirect_valid;
    assign bus.instr       = fifo_word[rd_ptr];
    assign bus.instr_pc    = fifo_pc[rd_ptr];
    assign bus.fsm_state   = state;

    assign req_fire = bus.imem_req && bus.imem_gnt;
    assign push     = (state == ST_WAIT) && bus.imem_rvalid && !bus.redirect_valid;
    assign pop      = bus.instr_valid && bus.instr_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_REQ;
            started  <= 1'b0;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else begin
            started <= 1'b1;
            if (bus.redirect_valid) begin
                fetch_pc <= {bus.redirect_pc[DATA_WIDTH-1:2], 2'b00};
                // An in-flight fetch still owes a response; DROP swallows it.
                case (state)
                    ST_WAIT, ST_DROP: state <= bus.imem_rvalid ? ST_REQ : ST_DROP;
                    default:          state <= ST_REQ;
                endcase
            end else begin
                case (state)
                    ST_REQ: begin
                        if (req_fire) begin
                            req_pc   <= fetch_pc;
                            fetch_pc <= fetch_pc + DATA_WIDTH'(4);
                            state    <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (bus.imem_rvalid) state <= ST_REQ;
                    end
                    ST_DROP: begin
                        if (bus.imem_rvalid) state <= ST_REQ;
                    end
                    default: state <= ST_REQ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_word[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (bus.redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_word[wr_ptr] <= bus.imem_rdata;
                fifo_pc[wr_ptr]   <= req_pc;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory responder with address scoreboard,
// decode-side monitor popping an expected {pc, word} queue.
module tb_fetch_unit;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fetch_unit_if #(.DATA_WIDTH(DW)) bus ();

    fetch_unit #(
        .DATA_WIDTH (DW),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [2*DW-1:0] exp_q[$];
    logic [DW-1:0]   addr_q[$];
    int              fires = 0;
    int              lat = 1;
    bit              pend = 1'b0;
    int              pend_cnt = 0;
    logic [DW-1:0]   pend_addr = '0;

    // clock
    initial begin
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] mem_word(input logic [DW-1:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check32(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // memory side: accept requests, check addresses, remember the outstanding fetch
    initial begin
        forever begin
            @(negedge clk);
            if (rst && bus.imem_req && bus.imem_gnt) begin
                fires++;
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL imem_addr: unexpected request at 0x%08h, want none", bus.imem_addr);
                end else begin
                    check32("imem_addr", bus.imem_addr, addr_q.pop_front());
                end
                pend      = 1'b1;
                pend_cnt  = lat;
                pend_addr = bus.imem_addr;
            end
            if (rst && bus.imem_rvalid) begin
                checks++;
                if (bus.fsm_state == 2'd0) begin
                    errors++;
                    $display("FAIL rvalid_in_req: got state %0d with rvalid, want WAIT or DROP", bus.fsm_state);
                end
            end
        end
    end

    // memory side: deliver the response lat cycles after the grant
    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.imem_rvalid = 1'b0;
            if (!rst) begin
                pend = 1'b0;
            end else if (pend) begin
                if (pend_cnt <= 1) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem_word(pend_addr);
                    pend = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
        end
    end

    // decode-side monitor
    initial begin
        logic [2*DW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst && bus.instr_valid && bus.instr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL instr: unexpected pc 0x%08h word 0x%08h, want none", bus.instr_pc, bus.instr);
                end else begin
                    e = exp_q.pop_front();
                    check32("instr_pc", bus.instr_pc, e[2*DW-1:DW]);
                    check32("instr", bus.instr, e[DW-1:0]);
                end
            end
        end
    end

    task automatic run_fires(input int target, input string name);
        int n = 0;
        while (fires < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (fires < target) begin
            errors++;
            $display("FAIL %s: got %0d requests, want %0d", name, fires, target);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || addr_q.size() != 0 || pend) && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0 || addr_q.size() != 0 || pend) begin
            errors++;
            $display("FAIL %s: got %0d instrs / %0d addrs outstanding, want 0", name, exp_q.size(), addr_q.size());
        end
    endtask

    task automatic pulse_redirect(input logic [DW-1:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        int base;
        int n;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_gnt       = 1'b0;
        bus.instr_ready    = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check32("rst_imem_req", 32'(bus.imem_req), 32'd0);
        check32("rst_imem_addr", bus.imem_addr, 32'h0);
        check32("rst_instr", bus.instr, 32'h0);
        check32("rst_instr_pc", bus.instr_pc, 32'h0);

        // sequential fetch from RESET_PC, immediate grant, 1-cycle response
        base = fires;
        lat  = 1;
        addr_q.push_back(32'h0);
        addr_q.push_back(32'h4);
        addr_q.push_back(32'h8);
        exp_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
        exp_q.push_back({32'h0000_0004, 32'hDEAD_BEEB});
        exp_q.push_back({32'h0000_0008, 32'hDEAD_BEE7});
        bus.instr_ready = 1'b1;
        bus.imem_gnt    = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_fires(base + 3, "seq_fires");
        bus.imem_gnt = 1'b0;
        wait_drain("seq_drain");

        // no grant: request held at a stable address
        @(negedge clk);
        check32("nogrant_req", 32'(bus.imem_req), 32'd1);
        check32("nogrant_addr", bus.imem_addr, 32'hC);

        // backpressure fills the buffer, then one pop allows one more fetch
        @(posedge clk);
        #1;
        base = fires;
        bus.instr_ready = 1'b0;
        addr_q.push_back(32'hC);
        addr_q.push_back(32'h10);
        addr_q.push_back(32'h14);
        exp_q.push_back({32'h0000_000C, 32'hDEAD_BEE3});
        exp_q.push_back({32'h0000_0010, 32'hDEAD_BEFF});
        exp_q.push_back({32'h0000_0014, 32'hDEAD_BEFB});
        bus.imem_gnt = 1'b1;
        run_fires(base + 2, "full_fires");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("full_req", 32'(bus.imem_req), 32'd0);
        check32("full_valid", 32'(bus.instr_valid), 32'd1);
        check32("full_head_pc", bus.instr_pc, 32'hC);
        @(posedge clk);
        #1;
        bus.instr_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_ready = 1'b0;
        run_fires(base + 3, "refill_fire");
        bus.imem_gnt = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("refull_req", 32'(bus.imem_req), 32'd0);
        @(posedge clk);
        #1;
        bus.instr_ready = 1'b1;
        wait_drain("full_drain");

        // redirect while WAIT, late response is dropped
        base = fires;
        lat  = 3;
        addr_q.push_back(32'h18);
        bus.imem_gnt = 1'b1;
        run_fires(base + 1, "wait_fire");
        lat = 1;
        addr_q.push_back(32'h100);
        addr_q.push_back(32'h104);
        exp_q.push_back({32'h0000_0100, 32'hDEAD_BFEF});
        exp_q.push_back({32'h0000_0104, 32'hDEAD_BFEB});
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h103;
        @(negedge clk);
        check32("redir_valid", 32'(bus.instr_valid), 32'd0);
        check32("redir_req", 32'(bus.imem_req), 32'd0);
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check32("redir_drop_state", 32'(bus.fsm_state), 32'd2);
        run_fires(base + 3, "redir_fires");
        bus.imem_gnt = 1'b0;
        wait_drain("redir_drain");

        // redirect coinciding with rvalid and a pending pop
        base = fires;
        lat  = 1;
        bus.instr_ready = 1'b0;
        addr_q.push_back(32'h108);
        addr_q.push_back(32'h10C);
        addr_q.push_back(32'h200);
        exp_q.push_back({32'h0000_0200, 32'hDEAD_BCEF});
        bus.imem_gnt = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #3;
            n++;
        end while (!(fires == base + 2 && bus.imem_rvalid) && n < 100);
        checks++;
        if (!(fires == base + 2 && bus.imem_rvalid)) begin
            errors++;
            $display("FAIL coll_setup: got %0d requests, want %0d with rvalid", fires - base, 2);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        bus.instr_ready    = 1'b1;
        @(negedge clk);
        check32("coll_valid", 32'(bus.instr_valid), 32'd0);
        check32("coll_req", 32'(bus.imem_req), 32'd0);
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        run_fires(base + 3, "coll_fires");
        bus.imem_gnt = 1'b0;
        wait_drain("coll_drain");

        // address wrap at the top of the space
        base = fires;
        pulse_redirect(32'hFFFF_FFFC);
        addr_q.push_back(32'hFFFF_FFFC);
        addr_q.push_back(32'h0);
        exp_q.push_back({32'hFFFF_FFFC, 32'h2152_4113});
        exp_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
        bus.imem_gnt = 1'b1;
        run_fires(base + 2, "wrap_fires");
        bus.imem_gnt = 1'b0;
        wait_drain("wrap_drain");

        // reset while WAIT with one buffered entry
        base = fires;
        lat  = 1;
        bus.instr_ready = 1'b0;
        addr_q.push_back(32'h4);
        addr_q.push_back(32'h8);
        bus.imem_gnt = 1'b1;
        run_fires(base + 1, "mid_fire0");
        lat = 3;
        run_fires(base + 2, "mid_fire1");
        #2;
        check32("mid_pre_valid", 32'(bus.instr_valid), 32'd1);
        rst = 1'b0;
        #1;
        check32("mid_rst_req", 32'(bus.imem_req), 32'd0);
        check32("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
        check32("mid_rst_pc", bus.instr_pc, 32'h0);
        lat = 1;
        addr_q.push_back(32'h0);
        exp_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.instr_ready = 1'b1;
        run_fires(base + 3, "restart_fire");
        bus.imem_gnt = 1'b0;
        wait_drain("restart_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
